// File: rtl/fp_soc_hex_pkg.sv
// fp_soc_hex_pkg: register map, bit positions and FSM encoding
// shared by the hex-display scroll controller and its frame buffer.
package fp_soc_hex_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_DWELL  = 3'd2;
  localparam logic [2:0] ADDR_PUSH   = 3'd3;
  localparam logic [2:0] ADDR_DIRECT = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CLEAR   = 2;

  localparam int ST_RUN  = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_soc_hex_frame_buf.sv
// fp_soc_hex_frame_buf: DEPTH x 16 frame store with fill count,
// sticky overflow flag and asynchronous read by frame index.
module fp_soc_hex_frame_buf
  import fp_soc_hex_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_push,
  input  logic        i_clear,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_rd_idx,
  output logic [15:0] o_rd_data,
  output logic [3:0]  o_count,
  output logic        o_overflow
);

  logic [15:0] r_mem [DEPTH];
  logic [3:0]  r_count;
  logic        r_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_push) begin
      if (r_count == 4'(DEPTH)) begin
        r_ovf <= 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (r_count == 4'(i)) r_mem[i] <= i_data;
        r_count <= r_count + 4'd1;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i_rd_idx == 4'(i)) o_rd_data = r_mem[i];
  end

  assign o_count    = r_count;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/fp_soc_hex_scroll_ctrl.sv
// fp_soc_hex_scroll_ctrl: Avalon-MM frame sequencer for the hex display.
// Steps through pushed frames every DWELL clocks; shows DIRECT when idle.
module fp_soc_hex_scroll_ctrl
  import fp_soc_hex_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] out_port,
  output logic        frame_tick
);

  logic               w_wr;
  logic               w_wr_ctrl;
  logic               w_wr_dwell;
  logic               w_wr_push;
  logic               w_wr_direct;
  logic               w_clear;
  logic               w_last;
  logic               w_unused;
  logic [15:0]        w_frame;
  logic [3:0]         w_count;
  logic               w_ovf;
  logic [DWELL_W-1:0] w_reload;
  logic [31:0]        w_ctrl_rd;
  logic [31:0]        w_status;

  state_e             r_state;
  state_e             w_state_nx;
  logic [3:0]         r_idx;
  logic [3:0]         w_idx_nx;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nx;
  logic               r_tick;
  logic               w_tick_nx;
  logic               r_en;
  logic               r_one;
  logic [DWELL_W-1:0] r_dwell;
  logic [15:0]        r_direct;
  logic [15:0]        r_out;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_dwell  = w_wr && (address == ADDR_DWELL);
  assign w_wr_push   = w_wr && (address == ADDR_PUSH);
  assign w_wr_direct = w_wr && (address == ADDR_DIRECT);
  assign w_clear     = w_wr_ctrl & writedata[CTRL_CLEAR];
  assign w_unused    = &{1'b0, writedata};

  fp_soc_hex_frame_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_wr_push),
    .i_clear    (w_clear),
    .i_data     (writedata[15:0]),
    .i_rd_idx   (r_idx),
    .o_rd_data  (w_frame),
    .o_count    (w_count),
    .o_overflow (w_ovf)
  );

  // A zero DWELL behaves as one clock per frame.
  assign w_reload = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
  assign w_last   = (r_idx + 4'd1) >= w_count;

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_tick_nx  = 1'b0;
    if (w_wr_ctrl) begin
      w_state_nx = S_IDLE;
      w_idx_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_en && (w_count != '0)) begin
            w_state_nx = S_SHOW;
            w_idx_nx   = '0;
            w_cnt_nx   = w_reload;
            w_tick_nx  = 1'b1;
          end
        end
        S_SHOW: begin
          if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - 1'b1;
          end else if (!w_last || !r_one) begin
            w_idx_nx  = w_last ? 4'd0 : r_idx + 4'd1;
            w_cnt_nx  = w_reload;
            w_tick_nx = 1'b1;
          end else begin
            w_state_nx = S_DONE;
          end
        end
        S_DONE: ;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_out    <= '0;
      r_en     <= 1'b0;
      r_one    <= 1'b0;
      r_dwell  <= '0;
      r_direct <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_tick  <= w_tick_nx;
      r_out   <= (r_state == S_IDLE) ? r_direct : w_frame;
      if (w_wr_ctrl) begin
        r_en  <= writedata[CTRL_EN];
        r_one <= writedata[CTRL_ONESHOT];
      end
      if (w_wr_dwell)  r_dwell  <= writedata[DWELL_W-1:0];
      if (w_wr_direct) r_direct <= writedata[15:0];
    end
  end

  always_comb begin
    w_ctrl_rd               = '0;
    w_ctrl_rd[CTRL_EN]      = r_en;
    w_ctrl_rd[CTRL_ONESHOT] = r_one;
    w_status                = '0;
    w_status[ST_RUN]        = (r_state == S_SHOW);
    w_status[ST_DONE]       = (r_state == S_DONE);
    w_status[ST_OVF]        = w_ovf;
    w_status[7:4]           = w_count;
    w_status[11:8]          = r_idx;
  end

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      (address == ADDR_CTRL):   readdata = w_ctrl_rd;
      (address == ADDR_STATUS): readdata = w_status;
      (address == ADDR_DWELL):  readdata = 32'(r_dwell);
      (address == ADDR_DIRECT): readdata = {16'd0, r_direct};
      default:                  readdata = '0;
    endcase
  end

  assign out_port   = r_out;
  assign frame_tick = r_tick;

endmodule
